result_ram_arbiter: RTL and testbench

Shares the Result RAM read port among N_REQ requesters, such as a UART dump unit, a checksum engine and a debug probe. Each request is an incrementing burst. Arbitration is round-robin at burst granularity. The block sits between the ResultMatrix read port and the requesters, and only grants access while results are valid and no write is in progress.

---
 rtl/result_ram_arbiter.sv | 144 ++++++++++++++
 tb/tb_result_ram_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/result_ram_arbiter.sv
// Round-robin, burst-granular arbiter sharing the Result RAM read port among N_REQ requesters.
// Reads are only issued while a completed product is present and no write is in progress.
module result_ram_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 7,
    parameter int unsigned RESULT_WIDTH = 24,
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned RAM_LATENCY  = 1
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            end_operation,
    input  logic                            write,
    input  logic [N_REQ-1:0]                req,
    input  logic [N_REQ*ADDR_WIDTH-1:0]     req_addr,
    input  logic [N_REQ*(ADDR_WIDTH+1)-1:0] req_len,
    output logic [N_REQ-1:0]                gnt,
    output logic [N_REQ-1:0]                rsp_valid,
    output logic [RESULT_WIDTH-1:0]         rsp_data,
    output logic [N_REQ-1:0]                done,
    output logic                            aborted,
    output logic                            ram_rd_en,
    output logic [ADDR_WIDTH-1:0]           ram_addr,
    input  logic [RESULT_WIDTH-1:0]         ram_rdata
);

    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned LEN_W = ADDR_WIDTH + 1;
    localparam logic [RAM_LATENCY-1:0] LAST_STAGE = RAM_LATENCY'(1) << (RAM_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                 state;
    logic [PTR_W-1:0]       ptr;
    logic [N_REQ-1:0]       owner;
    logic [LEN_W-1:0]       remaining;
    logic                   abort_flag;
    logic [RAM_LATENCY-1:0] pipe;

    logic                   gate_ok;
    logic                   any_req;
    logic [PTR_W-1:0]       win;
    logic [N_REQ-1:0]       win_oh;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [LEN_W-1:0]       sel_len;
    logic                   early_pending;
    int unsigned            idx;

    assign gate_ok       = end_operation & ~write;
    // The read strobe reacts to the gate in the same cycle so an abort never issues one more read.
    assign ram_rd_en     = (state == ISSUE) && gate_ok;
    assign early_pending = |(pipe & ~LAST_STAGE);
    assign win_oh        = N_REQ'(1) << win;
    assign sel_addr      = req_addr[win*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_len       = req_len[win*LEN_W +: LEN_W];

    // First requesting index after the last winner, wrapping modulo N_REQ.
    always_comb begin
        any_req = 1'b0;
        win     = ptr;
        idx     = 0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            idx = (32'(ptr) + i) % N_REQ;
            if (!any_req && req[idx]) begin
                any_req = 1'b1;
                win     = PTR_W'(idx);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= PTR_W'(N_REQ - 1);
            owner      <= '0;
            remaining  <= '0;
            abort_flag <= 1'b0;
            pipe       <= '0;
            gnt        <= '0;
            done       <= '0;
            aborted    <= 1'b0;
            rsp_valid  <= '0;
            rsp_data   <= '0;
            ram_addr   <= '0;
        end else begin
            gnt     <= '0;
            done    <= '0;
            aborted <= 1'b0;

            // Read-return pipeline: the last stage marks the cycle ram_rdata is valid.
            pipe[0] <= ram_rd_en;
            for (int i = 1; i < RAM_LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
            end
            if (pipe[RAM_LATENCY-1]) begin
                rsp_valid <= owner;
                rsp_data  <= ram_rdata;
            end else begin
                rsp_valid <= '0;
            end

            case (state)
                IDLE: begin
                    if (gate_ok && any_req) begin
                        ptr       <= win;
                        owner     <= win_oh;
                        gnt       <= win_oh;
                        remaining <= sel_len;
                        if (sel_len != '0) begin
                            ram_addr <= sel_addr;
                            state    <= ISSUE;
                        end else begin
                            state    <= DONE;
                        end
                    end
                end
                ISSUE: begin
                    if (!gate_ok) begin
                        abort_flag <= 1'b1;
                        state      <= DRAIN;
                    end else if (remaining == LEN_W'(1)) begin
                        state <= DRAIN;
                    end else begin
                        remaining <= remaining - LEN_W'(1);
                        ram_addr  <= ram_addr + ADDR_WIDTH'(1);
                    end
                end
                // Leave once only the final capture stage can still hold a read.
                DRAIN: begin
                    if (!early_pending) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    done       <= owner;
                    aborted    <= abort_flag;
                    abort_flag <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_result_ram_arbiter.sv
// Self-checking bench for result_ram_arbiter: burst table, round robin, gating, abort/wrap, reset.
module tb_result_ram_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        end_operation = 1'b1;
    logic        write = 1'b0;
    logic [3:0]  req = '0;
    logic [27:0] req_addr = '0;
    logic [31:0] req_len = '0;
    logic [3:0]  gnt;
    logic [3:0]  rsp_valid;
    logic [23:0] rsp_data;
    logic [3:0]  done;
    logic        aborted;
    logic        ram_rd_en;
    logic [6:0]  ram_addr;
    logic [23:0] ram_rdata = '0;

    result_ram_arbiter dut (
        .clock(clock), .reset(reset), .end_operation(end_operation), .write(write),
        .req(req), .req_addr(req_addr), .req_len(req_len), .gnt(gnt),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .done(done), .aborted(aborted),
        .ram_rd_en(ram_rd_en), .ram_addr(ram_addr), .ram_rdata(ram_rdata)
    );

    always #5 clock = ~clock;

    typedef struct {logic [3:0] who; logic [23:0] data;} rsp_t;
    typedef struct {int r; int addr; int len; logic [3:0] exp_gnt; int exp_done_off; int exp_reads;} vec_t;

    rsp_t       sb[$];
    logic [6:0] exp_addr[$];
    int  total = 0, bad = 0, cyc = 0;
    int  gnt_cnt = 0, done_cnt = 0, rsp_cnt = 0, rd_cnt = 0;
    bit  sb_off = 1'b0;

    function automatic logic [23:0] mem_val(input logic [6:0] a);
        return {8'hA5, 1'b0, a, ~{1'b0, a}};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // RAM model with one cycle of read latency.
    always @(posedge clock) if (ram_rd_en) ram_rdata <= mem_val(ram_addr);
    always @(posedge clock) cyc <= cyc + 1;

    // Output monitor and scoreboard, sampled mid-cycle.
    always @(negedge clock) begin
        if (gnt != 0) begin gnt_cnt++; check("gnt_onehot", 64'($onehot(gnt)), 1); end
        if (done != 0) begin done_cnt++; check("done_onehot", 64'($onehot(done)), 1); end
        if (ram_rd_en) begin
            rd_cnt++;
            if (!sb_off) begin
                if (exp_addr.size() == 0) check("rd_unexpected", 1, 0);
                else check("ram_addr", ram_addr, exp_addr.pop_front());
            end
        end
        if (rsp_valid != 0) begin
            rsp_t e;
            rsp_cnt++;
            if (!sb_off) begin
                if (sb.size() == 0) check("rsp_unexpected", rsp_valid, 0);
                else begin
                    e = sb.pop_front();
                    check("rsp_who", rsp_valid, e.who);
                    check("rsp_data", rsp_data, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock); #2;
    endtask

    task automatic wait_gnt(output int g);
        g = -1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (gnt != 0) begin g = cyc; break; end
        end
    endtask

    task automatic wait_done(output int d);
        d = -1;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (done != 0) begin d = cyc; break; end
        end
    endtask

    task automatic set_req(input int r, input int a, input int l);
        req_addr[r*7 +: 7] = 7'(a);
        req_len[r*8 +: 8]  = 8'(l);
        req[r]             = 1'b1;
    endtask

    task automatic expect_reads(input int r, input int a, input int n);
        rsp_t e;
        for (int k = 0; k < n; k++) begin
            exp_addr.push_back(7'(a + k));
            e.who  = 4'(1 << r);
            e.data = mem_val(7'(a + k));
            sb.push_back(e);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int t, g, d, rd0, rsp0;
        tick();
        set_req(v.r, v.addr, v.len);
        t = cyc; rd0 = rd_cnt; rsp0 = rsp_cnt;
        expect_reads(v.r, v.addr, v.len);
        wait_gnt(g);
        req[v.r] = 1'b0;
        check("gnt_val", gnt, v.exp_gnt);
        check("gnt_cyc", 64'(g), 64'(t + 1));
        wait_done(d);
        check("done_val", done, v.exp_gnt);
        check("done_cyc", 64'(d), 64'(t + v.exp_done_off));
        check("aborted", aborted, 0);
        check("reads", 64'(rd_cnt - rd0), 64'(v.exp_reads));
        check("rsps", 64'(rsp_cnt - rsp0), 64'(v.exp_reads));
    endtask

    task automatic do_reset();
        tick(); reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
    endtask

    initial begin
        vec_t       vecs[5];
        logic [3:0] rr_order[5];
        int t, g, d, prev_d, c0, g0, rd0, rsp0, dn0;

        vecs[0] = '{0,   5, 3, 4'b0001,  6, 3};
        vecs[1] = '{2, 127, 2, 4'b0100,  5, 2};
        vecs[2] = '{1,  64, 1, 4'b0010,  4, 1};
        vecs[3] = '{3,  40, 0, 4'b1000,  2, 0};
        vecs[4] = '{0, 120, 8, 4'b0001, 11, 8};
        rr_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        // Reset state
        tick(); tick(); #1;
        check("rst_outputs", {gnt, rsp_valid, done, aborted, ram_rd_en, ram_addr, rsp_data},
              '0);
        reset = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Round robin with all requesters held
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 20 + i, 1);
        for (int i = 0; i < 5; i++) expect_reads(i % 4, 20 + (i % 4), 1);
        prev_d = -1;
        for (int i = 0; i < 5; i++) begin
            wait_gnt(g);
            if (i == 4) req = '0;
            check("rr_gnt", gnt, rr_order[i]);
            if (i > 0) check("rr_gap", 64'(g), 64'(prev_d + 1));
            wait_done(d);
            check("rr_done", done, rr_order[i]);
            prev_d = d;
        end

        // Gating by write
        tick();
        write = 1'b1;
        set_req(2, 60, 2);
        c0 = cyc; g0 = gnt_cnt;
        expect_reads(2, 60, 2);
        while (cyc < c0 + 10) tick();
        check("gated_no_gnt", 64'(gnt_cnt - g0), 0);
        write = 1'b0;
        wait_gnt(g);
        req[2] = 1'b0;
        check("gate_gnt", gnt, 4'b0100);
        check("gate_gnt_cyc", 64'(g), 64'(c0 + 11));
        wait_done(d);
        check("gate_done_cyc", 64'(d), 64'(c0 + 15));

        // Abort with address wrap
        tick();
        set_req(1, 126, 6);
        t = cyc; rd0 = rd_cnt; rsp0 = rsp_cnt;
        expect_reads(1, 126, 3);
        wait_gnt(g);
        req[1] = 1'b0;
        check("abort_gnt_cyc", 64'(g), 64'(t + 1));
        tick(); tick(); tick();
        end_operation = 1'b0;
        wait_done(d);
        check("abort_done", done, 4'b0010);
        check("abort_flag", aborted, 1);
        check("abort_reads", 64'(rd_cnt - rd0), 3);
        check("abort_rsps", 64'(rsp_cnt - rsp0), 3);
        end_operation = 1'b1;
        run_vec('{1, 10, 2, 4'b0010, 5, 2});

        // Reset in the middle of a long burst
        sb_off = 1'b1;
        tick();
        set_req(0, 30, 8);
        wait_gnt(g);
        req[0] = 1'b0;
        check("rst_burst_gnt", gnt, 4'b0001);
        tick(); tick(); tick();
        reset = 1'b1;
        #1;
        check("rst_mid_outputs", {gnt, rsp_valid, done, aborted, ram_rd_en, ram_addr, rsp_data},
              '0);
        tick(); tick();
        reset = 1'b0;
        sb.delete(); exp_addr.delete();
        sb_off = 1'b0;
        dn0 = done_cnt; rsp0 = rsp_cnt; rd0 = rd_cnt;
        for (int i = 0; i < 15; i++) tick();
        check("post_rst_done", 64'(done_cnt - dn0), 0);
        check("post_rst_rsp", 64'(rsp_cnt - rsp0), 0);
        check("post_rst_rd", 64'(rd_cnt - rd0), 0);

        check("sb_empty", 64'(sb.size()), 0);
        check("addr_q_empty", 64'(exp_addr.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
